sign_mag_accum: RTL and testbench

SIGN_MAG_ACCUM -- requirements
Module: sign_mag_accum

---
 rtl/sign_mag_accum.sv | 156 +++++++++++++++
 tb/tb_sign_mag_accum.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sign_mag_accum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sign_mag_accum                                               |
// | Description : Packet accumulator for sign-magnitude operands. Beats        |
// |               arrive on a valid/ready input stream. On the last beat the   |
// |               block moves to HOLD and presents the packet sum together     |
// |               with a sticky overflow flag and a saturating beat count. It  |
// |               stays in HOLD until the consumer takes the result.           |
// |                                                                            |
// | Parameters  : N      operand/result width, bit N-1 = sign (3..16)          |
// |               CNT_W  width of the beat counter                             |
// |                                                                            |
// | Ports       : clk        rising-edge clock for all state                   |
// |               reset_n    asynchronous active-low reset                     |
// |               in_valid   operand beat present                              |
// |               in_ready   block can accept a beat (low only in HOLD)        |
// |               in_data    sign-magnitude operand                            |
// |               in_last    final beat of packet, qualified by in_valid       |
// |               out_valid  packet result available (high exactly in HOLD)    |
// |               out_ready  consumer accepts result                           |
// |               out_sum    packet sum, sign-magnitude                        |
// |               out_ovf    sticky overflow of any partial sum in the packet  |
// |               out_count  beats accepted in packet, saturating              |
// |                                                                            |
// | Build macro : SIGN_MAG_SAT_EN - when defined, an overflowed partial sum    |
// |               saturates to the largest magnitude; otherwise it wraps to    |
// |               its low N-1 magnitude bits. out_ovf is the same in both.     |
// |                                                                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sign_mag_accum #(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_sum,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t             r_state;
    logic [N-1:0]       r_acc;
    logic               r_ovf;
    logic [CNT_W-1:0]   r_count;

    logic               w_beat;
    logic               w_acc_sign;
    logic [N-2:0]       w_acc_mag;
    logic               w_in_sign;
    logic [N-2:0]       w_in_mag;
    logic               w_exact_sign;
    logic [N-1:0]       w_exact_mag;   // one guard bit above the magnitude
    logic               w_ovf;
    logic [N-2:0]       w_res_mag;
    logic               w_res_sign;
    logic [N-1:0]       w_next_acc;
    logic [CNT_W-1:0]   w_next_count;

    // Handshake flags depend on the state register only.
    assign in_ready  = (r_state != S_HOLD);
    assign out_valid = (r_state == S_HOLD);
    assign w_beat    = in_valid & in_ready;

    assign out_sum   = r_acc;
    assign out_ovf   = r_ovf;
    assign out_count = r_count;

    // Operand decode. A negative zero on the input is folded to +0 so it
    // can never steer the sign of a difference.
    assign w_acc_sign = r_acc[N-1];
    assign w_acc_mag  = r_acc[N-2:0];
    assign w_in_mag   = in_data[N-2:0];
    assign w_in_sign  = in_data[N-1] & (|w_in_mag);

    // Exact sign-magnitude sum. Only like-signed addition can reach the
    // guard bit; a difference always fits in N-1 bits.
    always_comb begin
        w_exact_sign = 1'b0;
        w_exact_mag  = '0;
        if (w_acc_sign == w_in_sign) begin
            w_exact_mag  = {1'b0, w_acc_mag} + {1'b0, w_in_mag};
            w_exact_sign = w_acc_sign;
        end else if (w_acc_mag >= w_in_mag) begin
            w_exact_mag  = {1'b0, w_acc_mag - w_in_mag};
            w_exact_sign = w_acc_sign;
        end else begin
            w_exact_mag  = {1'b0, w_in_mag - w_acc_mag};
            w_exact_sign = w_in_sign;
        end
    end

    assign w_ovf = w_exact_mag[N-1];

`ifdef SIGN_MAG_SAT_EN
    assign w_res_mag = w_ovf ? {(N-1){1'b1}} : w_exact_mag[N-2:0];
`else
    assign w_res_mag = w_exact_mag[N-2:0];
`endif

    // Any zero magnitude, exact or wrapped, is stored as +0.
    assign w_res_sign = w_exact_sign & (|w_res_mag);
    assign w_next_acc = {w_res_sign, w_res_mag};

    assign w_next_count = (&r_count) ? r_count : (r_count + c_cnt_one);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_count <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_ACCUM: begin
                    if (w_beat) begin
                        r_acc   <= w_next_acc;
                        r_ovf   <= r_ovf | w_ovf;
                        r_count <= w_next_count;
                        r_state <= in_last ? S_HOLD : S_ACCUM;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                        r_acc   <= '0;
                        r_ovf   <= 1'b0;
                        r_count <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_acc   <= '0;
                    r_ovf   <= 1'b0;
                    r_count <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sign_mag_accum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sign_mag_accum                                            |
// | Description : Self-checking bench for sign_mag_accum (N=4, CNT_W=8).       |
// |               Expected results come from an integer reference model that   |
// |               sums signed values and applies the overflow rule of the      |
// |               selected build (SIGN_MAG_SAT_EN).                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sign_mag_accum;

    localparam int N     = 4;
    localparam int CNT_W = 8;
    localparam int MAXM  = (1 << (N - 1)) - 1;

    logic             clk;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_sum;
    logic             out_ovf;
    logic [CNT_W-1:0] out_count;

    int total = 0;
    int bad   = 0;

    sign_mag_accum #(.N(N), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic int sm2int(input logic [N-1:0] v);
        int m;
        m = int'(v[N-2:0]);
        return v[N-1] ? -m : m;
    endfunction

    function automatic logic [N-1:0] int2sm(input int x);
        logic [N-1:0] r;
        int m;
        m = (x < 0) ? -x : x;
        r[N-2:0] = (N-1)'(m);
        r[N-1]   = (x < 0);
        return r;
    endfunction

    // One accepted beat: exact integer sum, then the build's overflow rule.
    function automatic int model_step(input int acc, input int v, inout bit ovf);
        int exact, m;
        exact = acc + v;
        m = (exact < 0) ? -exact : exact;
        if (m > MAXM) begin
            ovf = 1'b1;
`ifdef SIGN_MAG_SAT_EN
            m = MAXM;
`else
            m = m % (MAXM + 1);
`endif
        end
        return (exact < 0) ? -m : m;
    endfunction

    // ---------------- drivers (no checks) ----------------
    task automatic beat(input logic [N-1:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #22;
        total++;
        if ({in_ready, out_valid, out_sum, out_ovf, out_count} !== {1'b1, 1'b0, 4'h0, 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL reset_state: got rdy=%b vld=%b sum=%b ovf=%b cnt=%0d want rdy=1 vld=0 sum=0000 ovf=0 cnt=0",
                     in_ready, out_valid, out_sum, out_ovf, out_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        // First rising edge after release must accept the beat.
        beat(4'b0101, 1'b1);
        total++;
        if ({out_valid, out_sum, out_count} !== {1'b1, 4'b0101, 8'd1}) begin
            bad++;
            $display("FAIL first_beat: got vld=%b sum=%b cnt=%0d want vld=1 sum=0101 cnt=1",
                     out_valid, out_sum, out_count);
        end
        take_result();
    endtask

    task automatic test_directed();
        logic [N-1:0] exp35;
`ifdef SIGN_MAG_SAT_EN
        exp35 = 4'b0111;
`else
        exp35 = 4'b0011;
`endif
        beat(4'b0011, 1'b0);
        beat(4'b0010, 1'b0);
        beat(4'b1001, 1'b1);
        total++;
        if ({out_valid, out_sum, out_ovf, out_count} !== {1'b1, 4'b0100, 1'b0, 8'd3}) begin
            bad++;
            $display("FAIL three_beat: got vld=%b sum=%b ovf=%b cnt=%0d want vld=1 sum=0100 ovf=0 cnt=3",
                     out_valid, out_sum, out_ovf, out_count);
        end
        take_result();

        beat(4'b0101, 1'b0);
        beat(4'b0110, 1'b1);
        total++;
        if ({out_valid, out_sum, out_ovf, out_count} !== {1'b1, exp35, 1'b1, 8'd2}) begin
            bad++;
            $display("FAIL overflow: got vld=%b sum=%b ovf=%b cnt=%0d want vld=1 sum=%b ovf=1 cnt=2",
                     out_valid, out_sum, out_ovf, out_count, exp35);
        end
        take_result();

        beat(4'b0011, 1'b0);
        beat(4'b1011, 1'b1);
        total++;
        if ({out_valid, out_sum} !== {1'b1, 4'b0000}) begin
            bad++;
            $display("FAIL cancel_zero: got vld=%b sum=%b want vld=1 sum=0000", out_valid, out_sum);
        end
        take_result();

        beat(4'b1000, 1'b1);
        total++;
        if ({out_valid, out_sum, out_count} !== {1'b1, 4'b0000, 8'd1}) begin
            bad++;
            $display("FAIL neg_zero: got vld=%b sum=%b cnt=%0d want vld=1 sum=0000 cnt=1",
                     out_valid, out_sum, out_count);
        end
        take_result();
    endtask

    task automatic test_backpressure();
        beat(4'b0011, 1'b0);
        beat(4'b0100, 1'b1);
        for (int i = 0; i < 5; i++) begin
            // Inputs wiggling during HOLD must be ignored.
            in_valid = 1'b1;
            in_data  = N'($urandom);
            in_last  = 1'($urandom);
            @(posedge clk);
            #1;
            total++;
            if ({in_ready, out_valid, out_sum, out_ovf, out_count} !== {1'b0, 1'b1, 4'b0111, 1'b0, 8'd2}) begin
                bad++;
                $display("FAIL hold_cycle%0d: got rdy=%b vld=%b sum=%b ovf=%b cnt=%0d want rdy=0 vld=1 sum=0111 ovf=0 cnt=2",
                         i, in_ready, out_valid, out_sum, out_ovf, out_count);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        take_result();
        total++;
        if ({in_ready, out_valid, out_ovf, out_count} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
            bad++;
            $display("FAIL hold_release: got rdy=%b vld=%b ovf=%b cnt=%0d want rdy=1 vld=0 ovf=0 cnt=0",
                     in_ready, out_valid, out_ovf, out_count);
        end
    endtask

    task automatic test_midreset();
        beat(4'b0011, 1'b0);
        beat(4'b0010, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({in_ready, out_valid, out_sum, out_ovf, out_count} !== {1'b1, 1'b0, 4'h0, 1'b0, 8'd0}) begin
            bad++;
            $display("FAIL midreset_clear: got rdy=%b vld=%b sum=%b ovf=%b cnt=%0d want rdy=1 vld=0 sum=0000 ovf=0 cnt=0",
                     in_ready, out_valid, out_sum, out_ovf, out_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL midreset_nopartial: got vld=%b want vld=0", out_valid);
        end
        beat(4'b0001, 1'b1);
        total++;
        if ({out_valid, out_sum, out_ovf, out_count} !== {1'b1, 4'b0001, 1'b0, 8'd1}) begin
            bad++;
            $display("FAIL midreset_next: got vld=%b sum=%b ovf=%b cnt=%0d want vld=1 sum=0001 ovf=0 cnt=1",
                     out_valid, out_sum, out_ovf, out_count);
        end
        // Reset while holding a result discards it.
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({out_valid, out_sum, out_count} !== {1'b0, 4'h0, 8'd0}) begin
            bad++;
            $display("FAIL holdreset_clear: got vld=%b sum=%b cnt=%0d want vld=0 sum=0000 cnt=0",
                     out_valid, out_sum, out_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_exhaustive();
        int acc;
        bit ovf;
        logic [N-1:0] exp;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                ovf = 1'b0;
                acc = model_step(0, sm2int(N'(a)), ovf);
                acc = model_step(acc, sm2int(N'(b)), ovf);
                exp = int2sm(acc);
                beat(N'(a), 1'b0);
                beat(N'(b), 1'b1);
                total++;
                if ({out_valid, out_sum, out_ovf, out_count} !== {1'b1, exp, ovf, 8'd2}) begin
                    bad++;
                    $display("FAIL pair %b+%b: got vld=%b sum=%b ovf=%b cnt=%0d want vld=1 sum=%b ovf=%b cnt=2",
                             N'(a), N'(b), out_valid, out_sum, out_ovf, out_count, exp, ovf);
                end
                take_result();
            end
        end
    endtask

    task automatic test_random();
        int acc, len, gap, waitc;
        bit ovf;
        logic [N-1:0] d;
        logic [N-1:0] exp;
        for (int p = 0; p < 40; p++) begin
            acc = 0;
            ovf = 1'b0;
            len = int'($urandom_range(1, 6));
            for (int k = 0; k < len; k++) begin
                gap = int'($urandom_range(0, 2));
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk);
                    #1;
                end
                d = N'($urandom);
                acc = model_step(acc, sm2int(d), ovf);
                beat(d, (k == len - 1));
            end
            exp = int2sm(acc);
            waitc = int'($urandom_range(0, 3));
            for (int w = 0; w < waitc; w++) begin
                @(posedge clk);
                #1;
            end
            total++;
            if ({out_valid, out_sum, out_ovf, out_count} !== {1'b1, exp, ovf, 8'(len)}) begin
                bad++;
                $display("FAIL random_pkt%0d: got vld=%b sum=%b ovf=%b cnt=%0d want vld=1 sum=%b ovf=%b cnt=%0d",
                         p, out_valid, out_sum, out_ovf, out_count, exp, ovf, len);
            end
            take_result();
        end
    endtask

    task automatic test_count_saturation();
        // +1 / -1 alternating keeps the sum at 0 after an even beat count.
        for (int k = 0; k < 260; k++) begin
            beat((k % 2 == 0) ? 4'b0001 : 4'b1001, (k == 259));
        end
        total++;
        if ({out_valid, out_sum, out_ovf, out_count} !== {1'b1, 4'b0000, 1'b0, 8'd255}) begin
            bad++;
            $display("FAIL count_sat: got vld=%b sum=%b ovf=%b cnt=%0d want vld=1 sum=0000 ovf=0 cnt=255",
                     out_valid, out_sum, out_ovf, out_count);
        end
        take_result();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_midreset();
        test_exhaustive();
        test_random();
        test_count_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
